// File: rtl/i2c_sched_pkg.sv
// Shared state encoding and response status codes for the i2c bus scheduler.
package i2c_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RECOVER,
    ST_RESP
  } state_e;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_NACK    = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;
  localparam logic [1:0] RSP_BAD_REQ = 2'b11;

endpackage

// File: rtl/i2c_bus_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr (wrapping), as one-hot and index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [PW-1:0]      grant_idx,
  output logic               any_req
);

  logic [PW:0] pos;

  // Walk from farthest to nearest so the position closest after ptr overrides the rest.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_req   = |req;
    pos       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = {1'b0, ptr} + (PW + 1)'(k);
      if (pos >= (PW + 1)'(NUM_REQ)) begin
        pos = pos - (PW + 1)'(NUM_REQ);
      end
      if (req[pos[PW-1:0]]) begin
        grant_oh              = '0;
        grant_oh[pos[PW-1:0]] = 1'b1;
        grant_idx             = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Round-robin sharing of one i2c master; req->m_start 2 cycles, m_done->rsp_valid 1 cycle; requests wait while busy.
// Optional WAIT watchdog enabled by defining I2C_SCHED_TIMEOUT_EN.
module i2c_bus_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BYTES      = 3,
  parameter int RECOVER_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int NB = $clog2(MAX_BYTES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rd_nwr,
  input  logic [NUM_REQ*7-1:0]           req_addr,
  input  logic [NUM_REQ*NB-1:0]          req_nbytes,
  input  logic [NUM_REQ*8*MAX_BYTES-1:0] req_din,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [1:0]                     rsp_status,
  output logic [8*MAX_BYTES-1:0]         rsp_dout,
  output logic                           m_start,
  output logic                           m_rd_nwr,
  output logic [6:0]                     m_addr,
  output logic [NB-1:0]                  m_nbytes,
  output logic [8*MAX_BYTES-1:0]         m_din,
  input  logic [8*MAX_BYTES-1:0]         m_dout,
  input  logic                           m_done,
  input  logic                           m_error,
  output logic                           m_reset,
  output logic                           busy
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int RCW = $clog2(RECOVER_CYCLES + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || RECOVER_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("i2c_bus_scheduler: parameter out of range");
  end

  state_e                   state_q;
  logic [PW-1:0]            ptr_q;
  logic [NUM_REQ-1:0]       g_oh_q;
  logic [RCW-1:0]           rec_cnt_q;
  logic                     resp_pend_q;
  logic                     recover_q;
  logic [NUM_REQ-1:0]       req_ack_q;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic [1:0]               rsp_status_q;
  logic [8*MAX_BYTES-1:0]   rsp_dout_q;
  logic                     m_start_q;
  logic                     m_rd_nwr_q;
  logic [6:0]               m_addr_q;
  logic [NB-1:0]            m_nbytes_q;
  logic [8*MAX_BYTES-1:0]   m_din_q;
`ifdef I2C_SCHED_TIMEOUT_EN
  logic [15:0]              wait_cnt_q;
`endif

  logic [NUM_REQ-1:0]       grant_oh;
  logic [PW-1:0]            grant_idx;
  logic                     any_req;

  logic                     rd_d;
  logic [6:0]               addr_d;
  logic [NB-1:0]            nbytes_d;
  logic [8*MAX_BYTES-1:0]   din_d;
  logic                     bad_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    rd_d     = 1'b0;
    addr_d   = '0;
    nbytes_d = '0;
    din_d    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        rd_d     = req_rd_nwr[i];
        addr_d   = req_addr[7*i +: 7];
        nbytes_d = req_nbytes[NB*i +: NB];
        din_d    = req_din[8*MAX_BYTES*i +: 8*MAX_BYTES];
      end
    end
    bad_d = (nbytes_d == '0) || (nbytes_d > NB'(MAX_BYTES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= PW'(NUM_REQ - 1);
      g_oh_q       <= '0;
      rec_cnt_q    <= '0;
      resp_pend_q  <= 1'b0;
      recover_q    <= 1'b0;
      req_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_status_q <= RSP_OK;
      rsp_dout_q   <= '0;
      m_start_q    <= 1'b0;
      m_rd_nwr_q   <= 1'b0;
      m_addr_q     <= '0;
      m_nbytes_q   <= '0;
      m_din_q      <= '0;
`ifdef I2C_SCHED_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
      m_start_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A sticky error left over from a previous master session is flushed silently.
          if (m_error) begin
            recover_q   <= 1'b1;
            rec_cnt_q   <= '0;
            resp_pend_q <= 1'b0;
            state_q     <= ST_RECOVER;
          end else if (any_req) begin
            req_ack_q <= grant_oh;
            ptr_q     <= grant_idx;
            g_oh_q    <= grant_oh;
            if (bad_d) begin
              rsp_status_q <= RSP_BAD_REQ;
              rsp_dout_q   <= '0;
              state_q      <= ST_RESP;
            end else begin
              m_rd_nwr_q <= rd_d;
              m_addr_q   <= addr_d;
              m_nbytes_q <= nbytes_d;
              m_din_q    <= din_d;
              state_q    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          m_start_q <= 1'b1;
`ifdef I2C_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (m_error) begin
            rsp_status_q <= RSP_NACK;
            rsp_dout_q   <= '0;
            resp_pend_q  <= 1'b1;
            recover_q    <= 1'b1;
            rec_cnt_q    <= '0;
            state_q      <= ST_RECOVER;
          end else if (m_done) begin
            rsp_status_q <= RSP_OK;
            rsp_dout_q   <= m_rd_nwr_q ? m_dout : '0;
            rsp_valid_q  <= g_oh_q;
            state_q      <= ST_RESP;
          end
`ifdef I2C_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            rsp_status_q <= RSP_TIMEOUT;
            rsp_dout_q   <= '0;
            resp_pend_q  <= 1'b1;
            recover_q    <= 1'b1;
            rec_cnt_q    <= '0;
            state_q      <= ST_RECOVER;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
`endif
        end
        ST_RECOVER: begin
          if (rec_cnt_q == RCW'(RECOVER_CYCLES - 1)) begin
            recover_q <= 1'b0;
            if (resp_pend_q) begin
              rsp_valid_q <= g_oh_q;
              state_q     <= ST_RESP;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            rec_cnt_q <= rec_cnt_q + RCW'(1);
          end
        end
        ST_RESP: begin
          // Bad requests arrive here without a pulse yet; emit it before returning to IDLE.
          if (|rsp_valid_q) begin
            resp_pend_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            rsp_valid_q <= g_oh_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ack    = req_ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_dout   = rsp_dout_q;
  assign m_start    = m_start_q;
  assign m_rd_nwr   = m_rd_nwr_q;
  assign m_addr     = m_addr_q;
  assign m_nbytes   = m_nbytes_q;
  assign m_din      = m_din_q;
  assign m_reset    = reset | recover_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Directed + randomized bench for i2c_bus_scheduler with a behavioural master and round-robin reference model.
module tb_i2c_bus_scheduler;

  localparam int N  = 4;
  localparam int MB = 3;
  localparam int NB = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid, req_rd_nwr;
  logic [N*7-1:0]  req_addr;
  logic [N*NB-1:0] req_nbytes;
  logic [N*24-1:0] req_din;
  logic [N-1:0]    req_ack, rsp_valid;
  logic [1:0]      rsp_status;
  logic [23:0]     rsp_dout;
  logic            m_start, m_rd_nwr;
  logic [6:0]      m_addr;
  logic [NB-1:0]   m_nbytes;
  logic [23:0]     m_din, m_dout;
  logic            m_done, m_error, m_reset, busy;

  i2c_bus_scheduler #(
    .NUM_REQ(N), .MAX_BYTES(MB), .RECOVER_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd_nwr(req_rd_nwr), .req_addr(req_addr),
    .req_nbytes(req_nbytes), .req_din(req_din),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_dout(rsp_dout),
    .m_start(m_start), .m_rd_nwr(m_rd_nwr), .m_addr(m_addr), .m_nbytes(m_nbytes),
    .m_din(m_din), .m_dout(m_dout), .m_done(m_done), .m_error(m_error),
    .m_reset(m_reset), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Behavioural master: mode 0 completes, 1 raises a sticky error, 2 never answers.
  int   mmode, mlat, mcnt;
  logic mbusy, inject_err;
  always @(posedge clk or posedge m_reset) begin
    if (m_reset) begin
      m_done  <= 1'b0;
      m_error <= 1'b0;
      mbusy   <= 1'b0;
      mcnt    <= 0;
    end else begin
      m_done <= 1'b0;
      if (inject_err) m_error <= 1'b1;
      if (m_start) begin
        mbusy <= 1'b1;
        mcnt  <= mlat;
      end else if (mbusy) begin
        if (mcnt == 0) begin
          mbusy <= 1'b0;
          if (mmode == 0) m_done <= 1'b1;
          else if (mmode == 1) m_error <= 1'b1;
        end else begin
          mcnt <= mcnt - 1;
        end
      end
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ptr_m = N - 1;
  logic [23:0] next_mdat;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic set_client(input int i, input logic rd, input logic [6:0] a,
                            input logic [NB-1:0] nb, input logic [23:0] d);
    req_rd_nwr[i]         = rd;
    req_addr[7*i +: 7]    = a;
    req_nbytes[NB*i +: NB] = nb;
    req_din[24*i +: 24]   = d;
  endtask

  task automatic rand_client(input int i, input bit allow_bad);
    logic [NB-1:0] nb;
    nb = allow_bad ? NB'($urandom_range(0, 3)) : NB'($urandom_range(1, 3));
    set_client(i, 1'($urandom_range(0, 1)), 7'($urandom), nb, 24'($urandom));
  endtask

  // Serve one grant from the current request set; DUT must be idle on entry.
  task automatic serve(input int mode, output int g);
    int cyc0, starts, rcnt, done_at, err_at, n;
    logic rd, bad;
    logic [NB-1:0] nb;
    logic [6:0] a;
    logic [23:0] din, mdat, exp_dout;
    logic [1:0] exp_st;
    cyc0 = cyc;
    g    = rr_pick(req_valid);
    rd   = req_rd_nwr[g];
    nb   = req_nbytes[NB*g +: NB];
    a    = req_addr[7*g +: 7];
    din  = req_din[24*g +: 24];
    bad  = (nb == 0) || (nb > MB);
    mmode = mode;
    mlat  = $urandom_range(0, 4);
    mdat  = next_mdat;
    if (rd) for (int k = 0; k < MB; k++) if (k >= nb) mdat[8*k +: 8] = 8'h00;
    m_dout = mdat;
    exp_st   = bad ? 2'b11 : 2'(mode);
    exp_dout = (!bad && mode == 0 && rd) ? mdat : 24'h0;

    tick();
    chk("req_ack", req_ack, 64'(4'b1 << g));
    ptr_m = g;
    req_valid[g] = 1'b0;
    tick();
    chk("m_start", m_start, !bad);
    if (!bad) begin
      chk("m_addr", m_addr, a);
      chk("m_rd_nwr", m_rd_nwr, rd);
      chk("m_nbytes", m_nbytes, nb);
      chk("m_din", m_din, din);
    end
    starts = 0; rcnt = 0; done_at = -1; err_at = -1; n = 0;
    while (rsp_valid == '0 && n < 400) begin
      tick();
      n++;
      if (m_start) starts++;
      if (m_reset) rcnt++;
      if (m_done && done_at < 0) done_at = cyc;
      if (m_error && err_at < 0) err_at = cyc;
    end
    chk("rsp_valid", rsp_valid, 64'(4'b1 << g));
    chk("rsp_status", rsp_status, exp_st);
    chk("rsp_dout", rsp_dout, exp_dout);
    chk("m_start_once", starts, 0);
    chk("busy_in_resp", busy, 1);
    if (bad)            chk("bad_latency", cyc, cyc0 + 2);
    else if (mode == 0) chk("done_latency", cyc, done_at + 1);
    else if (mode == 1) chk("nack_latency", cyc, err_at + 5);
    else                chk("timeout_latency", cyc, cyc0 + 2 + 100 + 4);
    chk("m_reset_cycles", rcnt, (!bad && mode != 0) ? 4 : 0);
    tick();
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("idle_after", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_reset"}, m_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_status"}, rsp_status, 0);
    chk({tag, "_rsp_dout"}, rsp_dout, 0);
    chk({tag, "_m_start"}, m_start, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_nbytes"}, m_nbytes, 0);
    chk({tag, "_m_din"}, m_din, 0);
  endtask

  initial begin
    int g, rcnt, rsp_seen, busy_seen, n;
    reset = 1'b1;
    req_valid = '0; req_rd_nwr = '0; req_addr = '0; req_nbytes = '0; req_din = '0;
    m_dout = '0; inject_err = 1'b0; mmode = 0; mlat = 0; next_mdat = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    chk("m_reset_released", m_reset, 0);
    ptr_m = N - 1;

    // Client 2 read of 2 bytes from 0x29.
    set_client(2, 1'b1, 7'h29, 2'd2, 24'h0);
    next_mdat = 24'h003412;
    req_valid = 4'b0100;
    serve(0, g);

    // Held requests 1011 from a fresh pointer: expected order 0,1,3,0,...
    reset = 1'b1; tick(); reset = 1'b0; tick();
    ptr_m = N - 1;
    rand_client(0, 0); rand_client(1, 0); rand_client(3, 0);
    req_valid = 4'b1011;
    for (int r = 0; r < 5; r++) begin
      next_mdat = 24'($urandom);
      serve(0, g);
      rand_client(g, 0);
      req_valid[g] = 1'b1;
    end
    for (int r = 0; r < N && req_valid != '0; r++) begin
      next_mdat = 24'($urandom);
      serve(0, g);
    end

    // Client 1 write answered with a NACK.
    set_client(1, 1'b0, 7'h50, 2'd2, 24'h00beef);
    req_valid = 4'b0010;
    next_mdat = 24'h123456;
    serve(1, g);

    // Stale error while idle: recovery pulse, no response.
    inject_err = 1'b1;
    rcnt = 0; rsp_seen = 0; busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_reset) begin rcnt++; inject_err = 1'b0; end
      if (rsp_valid != '0) rsp_seen++;
      if (busy) busy_seen++;
    end
    inject_err = 1'b0;
    chk("stale_m_reset_cycles", rcnt, 4);
    chk("stale_no_rsp", rsp_seen, 0);
    chk("stale_busy_seen", busy_seen != 0, 1);
    chk("stale_idle", busy, 0);

    // Zero-length request is rejected without touching the master.
    set_client(0, 1'b1, 7'h11, 2'd0, 24'h0);
    req_valid = 4'b0001;
    serve(0, g);

    // Randomized mix of requesters, lengths, NACKs and latencies.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          rand_client(i, 1);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        n = $urandom_range(0, N - 1);
        rand_client(n, 1);
        req_valid[n] = 1'b1;
      end
      next_mdat = 24'($urandom);
      serve(($urandom_range(0, 4) == 0) ? 1 : 0, g);
    end
    for (int r = 0; r < N && req_valid != '0; r++) begin
      next_mdat = 24'($urandom);
      serve(0, g);
    end

`ifdef I2C_SCHED_TIMEOUT_EN
    // Silent slave: watchdog reports TIMEOUT after recovery.
    set_client(3, 1'b1, 7'h3a, 2'd3, 24'h0);
    req_valid = 4'b1000;
    next_mdat = 24'hffffff;
    serve(2, g);
`endif

    // Silent slave, then asynchronous reset in the middle of WAIT.
    set_client(2, 1'b1, 7'h22, 2'd1, 24'h0);
    req_valid = 4'b0100;
    mmode = 2;
    tick();
    chk("stall_ack", req_ack, 4'b0100);
    req_valid = '0;
    rsp_seen = 0;
`ifdef I2C_SCHED_TIMEOUT_EN
    n = 20;
`else
    n = 150;
`endif
    for (int i = 0; i < n; i++) begin
      tick();
      if (rsp_valid != '0) rsp_seen++;
    end
    chk("stall_busy", busy, 1);
    chk("stall_no_rsp", rsp_seen, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    tick();
    reset = 1'b0;
    tick();
    ptr_m = N - 1;
    set_client(1, 1'b1, 7'h44, 2'd3, 24'h0);
    req_valid = 4'b0010;
    next_mdat = 24'hc0ffee;
    serve(0, g);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
